// File: rtl/mem_bus_adapter.sv
// Memory-stage to valid/ready data-bus adapter: one bus transaction per load/store,
// lane steering for stores, aligned and extended load return, error and timeout faults.
module mem_bus_adapter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [31:0] mem_load_data,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_strb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int             CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               access;

    logic               req_write_p0;
    logic [31:0]        req_addr_p0;
    logic [31:0]        req_wdata_p0;
    logic [3:0]         req_strb_p0;
    logic [1:0]         req_off_p0;
    logic [1:0]         req_size_p0;
    logic               req_signed_p0;

    logic [31:0]        load_data_p1;
    logic               fault_p1;

    // Byte enables for a store; loads always fetch the whole word.
    function automatic logic [3:0] store_strb(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the right-aligned store data across every lane it could occupy.
    function automatic logic [31:0] store_wdata(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] wdata;
        case (size)
            2'b00:   wdata = {4{data[7:0]}};
            2'b01:   wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
        logic        [31:0] shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic        [31:0] result;
        shifted = rdata >> {off, 3'b000};
        byte_s  = signed'(shifted[7:0]);
        half_s  = signed'(shifted[15:0]);
        case (size)
            2'b00: begin
                if (sgn) result = 32'(byte_s);
                else     result = {24'b0, shifted[7:0]};
            end
            2'b01: begin
                if (sgn) result = 32'(half_s);
                else     result = {16'b0, shifted[15:0]};
            end
            default: result = shifted;
        endcase
        return result;
    endfunction

    assign access = mem_load | mem_store;

    always_comb begin
        state_nx      = state;
        mem_stall     = 1'b0;
        bus_req_valid = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = access;
                if (access) state_nx = REQ;
            end
            REQ: begin
                mem_stall     = 1'b1;
                bus_req_valid = 1'b1;
                if (bus_req_ready) state_nx = WAIT;
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (bus_resp_valid) state_nx = DONE;
                else if (TO_EN && wait_cnt == CNT_LAST) state_nx = DONE;
            end
            DONE: begin
                // Never loop back to REQ here: the instruction is still on the inputs.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            req_write_p0  <= 1'b0;
            req_addr_p0   <= '0;
            req_wdata_p0  <= '0;
            req_strb_p0   <= '0;
            req_off_p0    <= '0;
            req_size_p0   <= '0;
            req_signed_p0 <= 1'b0;
            load_data_p1  <= '0;
            fault_p1      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                // p0: request capture, held stable until the bus accepts it
                IDLE: begin
                    if (access) begin
                        req_write_p0  <= mem_store;
                        req_addr_p0   <= {mem_address[31:2], 2'b00};
                        req_wdata_p0  <= store_wdata(mem_store_data, mem_size);
                        req_strb_p0   <= mem_store ? store_strb(mem_address[1:0], mem_size) : 4'b1111;
                        req_off_p0    <= mem_address[1:0];
                        req_size_p0   <= mem_size;
                        req_signed_p0 <= mem_signed;
                    end
                end
                REQ: begin
                    if (bus_req_ready) wait_cnt <= '0;
                end
                // p1: response capture
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (bus_resp_valid) begin
                        fault_p1 <= bus_resp_error;
                        if (!req_write_p0)
                            load_data_p1 <= load_extend(bus_resp_rdata, req_off_p0,
                                                        req_size_p0, req_signed_p0);
                    end else if (TO_EN && wait_cnt == CNT_LAST) begin
                        fault_p1     <= 1'b1;
                        load_data_p1 <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_load_data = load_data_p1;
    assign mem_fault     = (state == DONE) && fault_p1;
    assign bus_req_write = req_write_p0;
    assign bus_req_addr  = req_addr_p0;
    assign bus_req_wdata = req_wdata_p0;
    assign bus_req_strb  = req_strb_p0;

endmodule
